// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and frame constants.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream, memory-write and status bundle between the loader and its surroundings.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  modport master (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count
  );
endinterface

// File: rtl/inst_mem_loader_word_assembler.sv
// Collects bytes LSB first into a 32-bit word; o_full marks the byte that completes it.
module inst_mem_loader_word_assembler
  import inst_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  // Right shift: after four loads the first byte sits in bits [7:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else begin
      if (i_clr)
        r_idx <= '0;
      else if (i_load)
        r_idx <= r_idx + 2'd1;
      if (i_load)
        r_word <= {i_byte, r_word[31:8]};
    end
  end

  assign o_full = i_load && (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word = r_word;

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core busy meanwhile.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  inst_mem_loader_if.master  bus
);

  state_t            r_state;
  logic              r_rx_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_word_count;
  logic [15:0]       r_len;

  logic              w_accept;
  logic              w_load;
  logic              w_clr;
  logic              w_full;
  logic [31:0]       w_word;
  logic [15:0]       w_len_full;
  logic [ADDR_W:0]   w_count_nxt;

  assign w_accept    = bus.rx_valid & r_rx_ready;
  assign w_load      = w_accept && (r_state == S_DATA);
  assign w_clr       = w_accept && (r_state == S_LEN_HI);
  assign w_len_full  = {bus.rx_data, r_len[7:0]};
  assign w_count_nxt = r_word_count + 1'b1;

  inst_mem_loader_word_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_load (w_load),
    .i_byte (bus.rx_data),
    .o_word (w_word),
    .o_full (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rx_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
      r_len        <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_state      <= S_LEN_LO;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
            r_busy       <= 1'b1;
            r_rx_ready   <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= bus.rx_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len_full;
            if (w_len_full == 16'd0) begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_rx_ready <= 1'b0;
            end else if (w_len_full > 16'(DEPTH)) begin
              r_state    <= S_ERR;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
              r_rx_ready <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // Word is complete in the assembler at this edge; drop ready for the write cycle.
          if (w_full) begin
            r_state    <= S_WRITE;
            r_rx_ready <= 1'b0;
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_word_count[ADDR_W-1:0];
          end
        end
        S_WRITE: begin
          r_word_count <= w_count_nxt;
          if (16'(w_count_nxt) == r_len) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_DATA;
            r_rx_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready   = r_rx_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = w_word;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: expected memory writes are queued and checked by a monitor.
module tb_inst_mem_loader;

  localparam int ADDR_W = 7;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  wr_t  sb_q[$];

  inst_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_mem_loader #(.DEPTH(128), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.mem_we === 1'b1) begin
      chk("wr_expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit tog);
    int t;
    t = 0;
    @(negedge clk);
    if (tog) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        bus.rx_valid = 1'b0;
        bus.rx_data  = ~b;
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("byte_timeout", 64'(t), 64'd0);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a,
                           input bit last, input bit tog, input bit chk_bp);
    sb_q.push_back('{addr: a, data: w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], tog);
    if (chk_bp) begin
      @(negedge clk);
      chk("bp_ready_low", 64'(bus.rx_ready), 64'd0);
      chk("bp_we_high", 64'(bus.mem_we), 64'd1);
      @(negedge clk);
      chk("bp_ready_after", 64'(bus.rx_ready), 64'(!last));
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_busy", 64'(bus.busy), 64'd1);
    chk("start_ready", 64'(bus.rx_ready), 64'd1);
    chk("start_done_clr", 64'(bus.done), 64'd0);
    chk("start_err_clr", 64'(bus.err), 64'd0);
    chk("start_wc_clr", 64'(bus.word_count), 64'd0);
  endtask

  task automatic wait_end(input bit exp_err, input int exp_wc);
    int t;
    t = 0;
    while (!(bus.done === 1'b1 || bus.err === 1'b1) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("end_timeout", 64'(t >= 40), 64'd0);
    chk("end_done", 64'(bus.done), 64'(!exp_err));
    chk("end_err", 64'(bus.err), 64'(exp_err));
    chk("end_busy", 64'(bus.busy), 64'd0);
    chk("end_ready", 64'(bus.rx_ready), 64'd0);
    chk("end_wc", 64'(bus.word_count), 64'(exp_wc));
    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_wc", 64'(bus.word_count), 64'd0);
    rst = 1'b0;

    // Two-word program
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'h00100513, 7'd0, 0, 0, 1);
    send_word(32'h00B502B3, 7'd1, 1, 0, 1);
    wait_end(0, 2);

    // Empty program
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_end(0, 0);

    // Oversized header, then stray bytes must be refused
    do_start();
    send_byte(8'h81, 0);
    send_byte(8'h00, 0);
    wait_end(1, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      chk("err_ready_low", 64'(bus.rx_ready), 64'd0);
    end
    bus.rx_valid = 1'b0;
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_end(0, 0);

    // Three words with gappy rx_valid
    do_start();
    send_byte(8'h03, 1);
    send_byte(8'h00, 1);
    send_word(32'h11223344, 7'd0, 0, 1, 1);
    send_word(32'hDEADBEEF, 7'd1, 0, 1, 1);
    send_word(32'h000000FF, 7'd2, 1, 1, 1);
    wait_end(0, 3);

    // Reset in the middle of word 1
    do_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_word(32'h0A0B0C0D, 7'd0, 0, 0, 1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_ready", 64'(bus.rx_ready), 64'd0);
    chk("midrst_wc", 64'(bus.word_count), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    repeat (3) @(negedge clk);
    chk("midrst_sb", 64'(sb_q.size()), 64'd0);
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'hCAFEF00D, 7'd0, 1, 0, 1);
    wait_end(0, 1);

    // Full-depth load, last write at index 127
    do_start();
    send_byte(8'h80, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_word({b, ~b, 8'hA5, b}, 7'(i), i == 127, 0, 0);
    end
    wait_end(0, 128);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
